i2c_txn_arbiter: RTL and testbench
==================================

# i2c_txn_arbiter

Shares the single `i2c_master` between two transaction requesters: port 0 is the MPU6050 gyro driver and port 1 is a second sensor or configuration client. It latches a complete register transaction from the granted requester and drives the master's control inputs. It sequences the master's start pulse, then qualifies `stop_int` after a minimum settle window. It returns read data with a one-cycle done/err pulse, and enforces a guard gap between transactions.

## Interface
Parameters:
- `MIN_WAIT`, 1000: cycles after start during which `m_stop` is ignored (stale-stop mask).
- `TIMEOUT`, 2000000: cycles after start before a transaction is aborted with err; must be > `MIN_WAIT`.
- `GUARD`, 100: idle cycles between a transaction's end and the next grant.
- `CNT_W`, 32: counter width.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high.
- `req0`, `req1`  in  1  transaction request; held high until done/err.
- `dev_addr0`, `dev_addr1`  in  7  device address.
- `mem_addr0`, `mem_addr1`  in  8  register address.
- `wdata0`, `wdata1`  in  64  write payload.
- `size0`, `size1`  in  4  byte count (0 = address-only write).
- `rw0`, `rw1`  in  1  1 = read.
- `gnt`  out  2  one-hot owner; held high from grant through the done/err cycle.
- `done`  out  2  one-cycle completion pulse to the owner.
- `err`  out  2  one-cycle timeout pulse to the owner.
- `rdata`  out  64  read data; valid on the done cycle and held until the next done.
- `busy`  out  1  high in every state except IDLE.
- `m_rst`  out  1  to master `rst_master`; high = master held/restarted.
- `m_dev_addr` (out, 7), `m_mem_addr` (out, 8), `m_data` (out, 64), `m_size` (out, 4), `m_rw` (out, 1): latched transaction fields.
- `m_stop`  in  1  master `stop_int`.
- `m_rdata`  in  64  master `data_read_out`.

## Operation
- **States:** IDLE, LAUNCH, RUN, FINISH, GUARD.
- **IDLE:**
  - If either `req` is high, pick the winner and go to LAUNCH.
  - Arbitration is round-robin. If both requests are high, grant the port that is not `last`. `last` resets to 1, so port 0 wins the first tie.
- **LAUNCH (1 cycle):**
  - `gnt[w]`=1.
  - All `m_*` fields are latched from port w; `m_rst`=1.
  - Counter cleared. `last`←w.
- **RUN:**
  - `m_rst`=0; counter increments each cycle.
  - Go to FINISH with ok when counter ≥ `MIN_WAIT` and `m_stop`=1.
  - Otherwise go to FINISH with timeout when counter = `TIMEOUT`.
  - If both conditions hold in the same cycle, ok wins.
- **FINISH (1 cycle):**
  - `m_rst`=1.
  - On ok: `done[w]`=1 and `rdata`←`m_rdata` (captured on the RUN→FINISH edge, valid in FINISH). Write transactions also update `rdata`.
  - On timeout: `err[w]`=1 and `rdata` is unchanged.
  - `gnt` drops at the end of FINISH.
- **GUARD:**
  - `m_rst`=1 for `GUARD` cycles; requests are ignored.
  - Then return to IDLE. `GUARD`=0 means FINISH→IDLE directly.
- **Request drop before grant:** the request is withdrawn.
- **Request drop after grant:** ignored; the transaction runs to completion and done/err still pulses.
- **Input fields after LAUNCH:** ignored, because the `m_*` outputs come from latched copies.
- **`m_rst` value:** high in every state except RUN, which keeps the master quiescent and gives a clean restart edge.

## Timing
- **Reset values:** state=IDLE; `gnt`, `done`, `err`, `busy`=0; `rdata`=0; `m_rst`=1; all `m_*` fields=0; counter=0; `last`=1.
- **Reset mid-transaction:** returns to IDLE on the next edge. No done/err is issued, and the requester must re-request.
- **Latency, `req` at edge t (IDLE):**
  - LAUNCH at t+1 (`gnt` high).
  - RUN from t+2 (`m_rst` falls).
  - Earliest done is at t+3+`MIN_WAIT`.
- **Timeout:** err is issued at t+3+`TIMEOUT`.
- **Back-to-back throughput:** FINISH, then `GUARD` cycles, then IDLE, then LAUNCH. The minimum start-to-start spacing is `MIN_WAIT`+`GUARD`+4 cycles.
- **Counter:** saturating, `CNT_W` bits; it does not wrap for `TIMEOUT` < 2^`CNT_W`.

## Structure
- **Shared package:** the state encoding constants, the port index constants (`PORT_GYRO`=0, `PORT_AUX`=1), and the default `MIN_WAIT`/`TIMEOUT`/`GUARD` values.
- **Sub-module:** a 2-way round-robin picker, `rr_pick2` (inputs `req[1:0]`, `last`; output one-hot winner, combinational). It is reused by later arbiters.
- The `i2c_master` is instantiated by the parent, not inside this block.

## Test plan
- **Single read:** `req0`=1 with addr 0x68/0x47, size 2, rw 1; the master model asserts `m_stop` at cycle 1500 with `m_rdata`=0x1234. Required: `m_rst` falls at t+2, `done`=01 one cycle after the stop, `rdata`=0x1234, then GUARD.
- **Contention:** `req0` and `req1` high together from reset. Required: port 0 is served, then port 1, then port 0 again. `gnt` is never 11, and the grant order alternates.
- **Stale stop:** `m_stop` is held high from start. Required: done is not issued before counter=`MIN_WAIT`, and fires at exactly t+3+`MIN_WAIT`.
- **Timeout:** `m_stop` never asserts. Required: `err`=10 at t+3+`TIMEOUT`, `rdata` unchanged, and the next request is served normally.
- **Withdraw/drop:** `req1` pulses for 1 cycle during port 0's RUN, so port 1 is never granted. `req0` drops during RUN, and done is still pulsed.
- **Reset mid-RUN:** required: next cycle has `gnt`=0, `m_rst`=1, `busy`=0, and no done/err is issued.

Source files
------------

// File: rtl/i2c_txn_arbiter_pkg.sv
// Shared types, port indices and default timing for the I2C transaction arbiter
// and its round-robin picker.
package i2c_txn_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_RUN    = 3'd2,
    ST_FINISH = 3'd3,
    ST_GUARD  = 3'd4
  } state_t;

  localparam logic [0:0] PORT_GYRO = 1'b0;
  localparam logic [0:0] PORT_AUX  = 1'b1;

  localparam int unsigned DEF_MIN_WAIT = 32'd1000;
  localparam int unsigned DEF_TIMEOUT  = 32'd2000000;
  localparam int unsigned DEF_GUARD    = 32'd100;

  typedef struct packed {
    logic [6:0]  dev_addr;
    logic [7:0]  mem_addr;
    logic [63:0] data;
    logic [3:0]  size;
    logic        rw;
  } txn_t;

  function automatic txn_t pick_txn(input logic sel, input txn_t p0, input txn_t p1);
    txn_t r;
    if (sel) begin
      r = p1;
    end else begin
      r = p0;
    end
    return r;
  endfunction

endpackage

// File: rtl/i2c_txn_arbiter_rr_pick2.sv
// Two-way round-robin picker: one-hot winner, ties go to the port that was
// not served last.
module rr_pick2
  import i2c_txn_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] win_o
);

  // Single requester wins outright; a tie alternates on last_i.
  always_comb begin
    win_o = 2'b00;
    if (req_i == 2'b11) begin
      win_o[PORT_GYRO] = last_i;
      win_o[PORT_AUX]  = ~last_i;
    end else begin
      win_o = req_i;
    end
  end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Shares one i2c_master between two requesters: latches the granted
// transaction, masks stale stops, times out hung transfers, and spaces grants.
module i2c_txn_arbiter
  import i2c_txn_arbiter_pkg::*;
#(
  parameter int unsigned MIN_WAIT = DEF_MIN_WAIT,
  parameter int unsigned TIMEOUT  = DEF_TIMEOUT,
  parameter int unsigned GUARD    = DEF_GUARD,
  parameter int unsigned CNT_W    = 32
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req0_i,
  input  logic        req1_i,
  input  logic [6:0]  dev_addr0_i,
  input  logic [6:0]  dev_addr1_i,
  input  logic [7:0]  mem_addr0_i,
  input  logic [7:0]  mem_addr1_i,
  input  logic [63:0] wdata0_i,
  input  logic [63:0] wdata1_i,
  input  logic [3:0]  size0_i,
  input  logic [3:0]  size1_i,
  input  logic        rw0_i,
  input  logic        rw1_i,
  output logic [1:0]  gnt_o,
  output logic [1:0]  done_o,
  output logic [1:0]  err_o,
  output logic [63:0] rdata_o,
  output logic        busy_o,
  output logic        m_rst_o,
  output logic [6:0]  m_dev_addr_o,
  output logic [7:0]  m_mem_addr_o,
  output logic [63:0] m_data_o,
  output logic [3:0]  m_size_o,
  output logic        m_rw_o,
  input  logic        m_stop_i,
  input  logic [63:0] m_rdata_i
);

  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MIN   = CNT_W'(MIN_WAIT);
  localparam logic [CNT_W-1:0] CNT_TMO   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_GLAST = CNT_W'(GUARD - 32'd1);

  state_t           state_q;
  logic [1:0]       gnt_q;
  logic [1:0]       done_q;
  logic [1:0]       err_q;
  logic [63:0]      rdata_q;
  logic             busy_q;
  logic             m_rst_q;
  logic             last_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  txn_t             txn_q;

  logic [1:0]       req_s;
  logic [1:0]       win_s;
  txn_t             txn0_s;
  txn_t             txn1_s;
  logic             stop_ok_s;
  logic             tmo_s;
  logic             guard_end_s;

  assign req_s  = {req1_i, req0_i};
  assign txn0_s = {dev_addr0_i, mem_addr0_i, wdata0_i, size0_i, rw0_i};
  assign txn1_s = {dev_addr1_i, mem_addr1_i, wdata1_i, size1_i, rw1_i};

  rr_pick2 u_pick (
    .req_i  (req_s),
    .last_i (last_q),
    .win_o  (win_s)
  );

  // Saturating increment so a long TIMEOUT can never wrap back under MIN_WAIT.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = CNT_MAX;
    end
  end

  assign stop_ok_s   = m_stop_i && (cnt_q >= CNT_MIN);
  assign tmo_s       = (cnt_q >= CNT_TMO);
  assign guard_end_s = (cnt_q == CNT_GLAST);

  // Transaction sequencer with all outputs registered on the state transitions.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      err_q   <= 2'b00;
      rdata_q <= 64'd0;
      busy_q  <= 1'b0;
      m_rst_q <= 1'b1;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      txn_q   <= '0;
    end else begin
      done_q <= 2'b00;
      err_q  <= 2'b00;
      case (state_q)
        ST_IDLE: begin
          if (win_s != 2'b00) begin
            state_q <= ST_LAUNCH;
            gnt_q   <= win_s;
            busy_q  <= 1'b1;
            m_rst_q <= 1'b1;
            last_q  <= win_s[PORT_AUX];
            cnt_q   <= '0;
            txn_q   <= pick_txn(win_s[PORT_AUX], txn0_s, txn1_s);
          end
        end
        ST_LAUNCH: begin
          state_q <= ST_RUN;
          m_rst_q <= 1'b0;
        end
        ST_RUN: begin
          cnt_q <= cnt_d;
          // A qualified stop beats a timeout landing in the same cycle.
          if (stop_ok_s) begin
            state_q <= ST_FINISH;
            m_rst_q <= 1'b1;
            done_q  <= gnt_q;
            rdata_q <= m_rdata_i;
          end else if (tmo_s) begin
            state_q <= ST_FINISH;
            m_rst_q <= 1'b1;
            err_q   <= gnt_q;
          end
        end
        ST_FINISH: begin
          gnt_q <= 2'b00;
          cnt_q <= '0;
          if (GUARD == 32'd0) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= ST_GUARD;
          end
        end
        ST_GUARD: begin
          if (guard_end_s) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= 2'b00;
          busy_q  <= 1'b0;
          m_rst_q <= 1'b1;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign gnt_o        = gnt_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign rdata_o      = rdata_q;
  assign busy_o       = busy_q;
  assign m_rst_o      = m_rst_q;
  assign m_dev_addr_o = txn_q.dev_addr;
  assign m_mem_addr_o = txn_q.mem_addr;
  assign m_data_o     = txn_q.data;
  assign m_size_o     = txn_q.size;
  assign m_rw_o       = txn_q.rw;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Table-driven bench for i2c_txn_arbiter with a completion scoreboard and a
// simple i2c_master stand-in driven from the vector records.
module tb_i2c_txn_arbiter;

  localparam int MW = 20;
  localparam int TO = 60;
  localparam int GD = 5;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        req0_i, req1_i;
  logic [6:0]  dev_addr0_i, dev_addr1_i;
  logic [7:0]  mem_addr0_i, mem_addr1_i;
  logic [63:0] wdata0_i, wdata1_i;
  logic [3:0]  size0_i, size1_i;
  logic        rw0_i, rw1_i;
  logic [1:0]  gnt_o, done_o, err_o;
  logic [63:0] rdata_o;
  logic        busy_o, m_rst_o;
  logic [6:0]  m_dev_addr_o;
  logic [7:0]  m_mem_addr_o;
  logic [63:0] m_data_o;
  logic [3:0]  m_size_o;
  logic        m_rw_o;
  logic        m_stop_i;
  logic [63:0] m_rdata_i;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  gnt;
    logic [6:0]  dev;
    logic [7:0]  mem;
    logic [63:0] wd;
    logic [3:0]  sz;
    logic        rw;
    int          stop_at;
    logic [63:0] mrd;
    logic        drop;
    logic        pulse1;
    logic        idle_chk;
  } vec_t;

  typedef struct {
    logic [1:0]  gnt;
    logic        is_err;
    logic [63:0] rd;
    int          at;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  vec_t        vecs[9];
  logic [63:0] model_rd;

  i2c_txn_arbiter #(
    .MIN_WAIT (MW),
    .TIMEOUT  (TO),
    .GUARD    (GD),
    .CNT_W    (16)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .req0_i       (req0_i),
    .req1_i       (req1_i),
    .dev_addr0_i  (dev_addr0_i),
    .dev_addr1_i  (dev_addr1_i),
    .mem_addr0_i  (mem_addr0_i),
    .mem_addr1_i  (mem_addr1_i),
    .wdata0_i     (wdata0_i),
    .wdata1_i     (wdata1_i),
    .size0_i      (size0_i),
    .size1_i      (size1_i),
    .rw0_i        (rw0_i),
    .rw1_i        (rw1_i),
    .gnt_o        (gnt_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .rdata_o      (rdata_o),
    .busy_o       (busy_o),
    .m_rst_o      (m_rst_o),
    .m_dev_addr_o (m_dev_addr_o),
    .m_mem_addr_o (m_mem_addr_o),
    .m_data_o     (m_data_o),
    .m_size_o     (m_size_o),
    .m_rw_o       (m_rw_o),
    .m_stop_i     (m_stop_i),
    .m_rdata_i    (m_rdata_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Completion monitor: every done/err pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (busy_o === 1'b1) chk("gnt_onehot", 64'(gnt_o == 2'b11), 64'd0);
    if ((done_o | err_o) != 2'b00) begin
      if (sb.size() == 0) begin
        chk("unexpected_done_err", 64'({done_o, err_o}), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("done",       64'(done_o),  64'(mon_e.is_err ? 2'b00 : mon_e.gnt));
        chk("err",        64'(err_o),   64'(mon_e.is_err ? mon_e.gnt : 2'b00));
        chk("rdata",      rdata_o,      mon_e.rd);
        chk("fin_gnt",    64'(gnt_o),   64'(mon_e.gnt));
        chk("fin_cycle",  64'(cyc),     64'(mon_e.at));
      end
    end
  end

  task automatic drive_fields(input vec_t v, input logic own, input logic scr);
    logic [6:0]  d;
    logic [7:0]  m;
    logic [63:0] w;
    logic [3:0]  s;
    logic        r;
    d = scr ? ~v.dev : v.dev;
    m = scr ? ~v.mem : v.mem;
    w = scr ? ~v.wd  : v.wd;
    s = scr ? ~v.sz  : v.sz;
    r = scr ? ~v.rw  : v.rw;
    if (own) begin
      dev_addr1_i = d; mem_addr1_i = m; wdata1_i = w; size1_i = s; rw1_i = r;
      dev_addr0_i = d ^ 7'h15; mem_addr0_i = m ^ 8'hA5; wdata0_i = w ^ 64'hF0F0_F0F0_0F0F_0F0F;
      size0_i = s ^ 4'h5; rw0_i = ~r;
    end else begin
      dev_addr0_i = d; mem_addr0_i = m; wdata0_i = w; size0_i = s; rw0_i = r;
      dev_addr1_i = d ^ 7'h15; mem_addr1_i = m ^ 8'hA5; wdata1_i = w ^ 64'hF0F0_F0F0_0F0F_0F0F;
      size1_i = s ^ 4'h5; rw1_i = ~r;
    end
  endtask

  task automatic chk_fields(input vec_t v, input string tag);
    chk({tag, "_dev"},  64'(m_dev_addr_o), 64'(v.dev));
    chk({tag, "_mem"},  64'(m_mem_addr_o), 64'(v.mem));
    chk({tag, "_data"}, m_data_o,          v.wd);
    chk({tag, "_size"}, 64'(m_size_o),     64'(v.sz));
    chk({tag, "_rw"},   64'(m_rw_o),       64'(v.rw));
  endtask

  // Called on a falling edge with the arbiter idle; returns once it is idle again.
  task automatic run_vec(input vec_t v);
    int   t;
    int   fin;
    int   win;
    logic own;
    logic seen;
    own = v.gnt[1];
    drive_fields(v, own, 1'b0);
    req0_i    = v.req[0];
    req1_i    = v.req[1];
    m_stop_i  = 1'b0;
    m_rdata_i = v.mrd;
    t   = cyc + 1;
    win = (v.stop_at > MW) ? v.stop_at : MW;
    if (v.stop_at >= 0 && win <= TO) begin
      fin      = t + 2 + win;
      model_rd = v.mrd;
      sb.push_back('{gnt: v.gnt, is_err: 1'b0, rd: v.mrd, at: fin});
    end else begin
      fin = t + 2 + TO;
      sb.push_back('{gnt: v.gnt, is_err: 1'b1, rd: model_rd, at: fin});
    end

    @(negedge clk);
    chk("launch_gnt",  64'(gnt_o),   64'(v.gnt));
    chk("launch_mrst", 64'(m_rst_o), 64'd1);
    chk("launch_busy", 64'(busy_o),  64'd1);
    chk_fields(v, "launch");
    drive_fields(v, own, 1'b1);
    if (v.drop) begin
      if (own) req1_i = 1'b0;
      else     req0_i = 1'b0;
    end

    seen = 1'b0;
    for (int n = 0; n < TO + 10 && !seen; n++) begin
      @(negedge clk);
      if (n == 0) chk("run_mrst", 64'(m_rst_o), 64'd0);
      if ((done_o | err_o) != 2'b00) begin
        seen = 1'b1;
        chk("finish_mrst", 64'(m_rst_o), 64'd1);
        chk_fields(v, "finish");
      end else begin
        if (v.stop_at >= 0 && cyc >= t + 1 + v.stop_at) m_stop_i = 1'b1;
        if (v.pulse1 && n == 3) req1_i = 1'b1;
        if (v.pulse1 && n == 4) req1_i = 1'b0;
      end
    end
    chk("done_or_err_seen", 64'(seen), 64'd1);
    m_stop_i = 1'b0;
    if (own) req1_i = 1'b0;
    else     req0_i = 1'b0;

    seen = 1'b0;
    for (int n = 0; n < GD + 10 && !seen; n++) begin
      @(negedge clk);
      if (!busy_o) seen = 1'b1;
    end
    chk("back_to_idle", 64'(seen), 64'd1);
    if (seen) chk("guard_len", 64'(cyc), 64'(fin + 1 + GD));

    if (v.idle_chk) begin
      for (int n = 0; n < 3; n++) begin
        @(negedge clk);
        chk("idle_gnt",  64'(gnt_o),  64'd0);
        chk("idle_busy", 64'(busy_o), 64'd0);
      end
    end
  endtask

  initial begin
    vecs[0] = '{req: 2'b11, gnt: 2'b01, dev: 7'h68, mem: 8'h47, wd: 64'd0, sz: 4'd2, rw: 1'b1,
                stop_at: 30, mrd: 64'h1234, drop: 1'b0, pulse1: 1'b0, idle_chk: 1'b0};
    vecs[1] = '{req: 2'b11, gnt: 2'b10, dev: 7'h1E, mem: 8'h10, wd: 64'h0011_2233_4455_6677, sz: 4'd8,
                rw: 1'b0, stop_at: 25, mrd: 64'hCAFE_F00D, drop: 1'b0, pulse1: 1'b0, idle_chk: 1'b0};
    vecs[2] = '{req: 2'b11, gnt: 2'b01, dev: 7'h68, mem: 8'h3B, wd: 64'd0, sz: 4'd6, rw: 1'b1,
                stop_at: MW, mrd: 64'h0102_0304_0506_0708, drop: 1'b0, pulse1: 1'b0, idle_chk: 1'b0};
    vecs[3] = '{req: 2'b10, gnt: 2'b10, dev: 7'h0C, mem: 8'h02, wd: 64'd0, sz: 4'd1, rw: 1'b1,
                stop_at: 0, mrd: 64'h55, drop: 1'b0, pulse1: 1'b0, idle_chk: 1'b0};
    vecs[4] = '{req: 2'b10, gnt: 2'b10, dev: 7'h0C, mem: 8'h03, wd: 64'd0, sz: 4'd1, rw: 1'b1,
                stop_at: -1, mrd: 64'hDEAD_BEEF, drop: 1'b0, pulse1: 1'b0, idle_chk: 1'b0};
    vecs[5] = '{req: 2'b01, gnt: 2'b01, dev: 7'h68, mem: 8'h6B, wd: 64'h80, sz: 4'd1, rw: 1'b0,
                stop_at: 21, mrd: 64'h77, drop: 1'b0, pulse1: 1'b1, idle_chk: 1'b1};
    vecs[6] = '{req: 2'b01, gnt: 2'b01, dev: 7'h68, mem: 8'h1A, wd: 64'd0, sz: 4'd0, rw: 1'b0,
                stop_at: 40, mrd: 64'h99, drop: 1'b1, pulse1: 1'b0, idle_chk: 1'b0};
    vecs[7] = '{req: 2'b10, gnt: 2'b10, dev: 7'h0D, mem: 8'h75, wd: 64'd0, sz: 4'd4, rw: 1'b1,
                stop_at: TO, mrd: 64'hABCD, drop: 1'b0, pulse1: 1'b0, idle_chk: 1'b0};
    vecs[8] = '{req: 2'b11, gnt: 2'b01, dev: 7'h68, mem: 8'h75, wd: 64'd0, sz: 4'd2, rw: 1'b1,
                stop_at: 22, mrd: 64'h4242, drop: 1'b0, pulse1: 1'b0, idle_chk: 1'b0};

    reset_i = 1'b1;
    req0_i = 1'b0; req1_i = 1'b0;
    drive_fields(vecs[0], 1'b0, 1'b0);
    m_stop_i = 1'b0; m_rdata_i = 64'd0;
    model_rd = 64'd0;
    repeat (3) @(negedge clk);
    chk("rst_gnt",   64'(gnt_o),   64'd0);
    chk("rst_done",  64'(done_o),  64'd0);
    chk("rst_err",   64'(err_o),   64'd0);
    chk("rst_busy",  64'(busy_o),  64'd0);
    chk("rst_rdata", rdata_o,      64'd0);
    chk("rst_mrst",  64'(m_rst_o), 64'd1);
    chk("rst_mdev",  64'(m_dev_addr_o), 64'd0);
    chk("rst_mdata", m_data_o,     64'd0);
    reset_i = 1'b0;

    for (int i = 0; i < 9; i++) begin
      if (i == 8) begin
        // Reset while the master is running: no completion may follow.
        drive_fields(vecs[0], 1'b0, 1'b0);
        req0_i = 1'b1;
        repeat (5) @(negedge clk);
        reset_i  = 1'b1;
        m_stop_i = 1'b1;
        @(negedge clk);
        chk("midrst_gnt",   64'(gnt_o),   64'd0);
        chk("midrst_mrst",  64'(m_rst_o), 64'd1);
        chk("midrst_busy",  64'(busy_o),  64'd0);
        chk("midrst_done",  64'(done_o | err_o), 64'd0);
        chk("midrst_rdata", rdata_o,      64'd0);
        reset_i = 1'b0;
        req0_i  = 1'b0;
        model_rd = 64'd0;
        repeat (MW + 10) @(negedge clk);
        chk("midrst_idle", 64'(busy_o), 64'd0);
        m_stop_i = 1'b0;
      end
      run_vec(vecs[i]);
    end

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
